mat_scalar_mul_seq: RTL and testbench

Sequential, parametrised matrix-by-scalar multiplier for the matrix coprocessor datapath. It accepts a full ROWS x COLS matrix of signed elements and one signed scalar on a start pulse, then processes one row per clock using COLS parallel lanes. It writes the result matrix into an output register and reports per-row and global overflow. It generalises the fixed 5-element row multiplier to arbitrary element width and matrix size, and adds a start/busy/done handshake.

---
 rtl/mat_scalar_mul_seq.sv | 175 +++++++++++++++++
 tb/tb_mat_scalar_mul_seq.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_scalar_mul_seq.sv
// ---------------------------------------------------------------------------
// mat_scalar_mul_seq
//
// Sequential matrix-by-scalar multiplier. A start pulse latches a full
// ROWS x COLS matrix of signed ELEM_W-bit elements together with a signed
// scalar. The block then processes one row per clock using COLS parallel
// multiply lanes and writes each finished row into the mat_out register.
// Per-row overflow flags are kept alongside the result.
//
// Optional build macro:
//   SAT_EN  - when defined, an overflowing lane saturates to the largest
//             positive or most negative ELEM_W-bit value. When undefined, the
//             lane result is the low ELEM_W bits of the product (wrap).
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-high; abandons any operation in flight
//   start     request a new operation; accepted only when not running
//   mat_in    source matrix; row 0 in the MSBs, element 0 of a row in that
//             row's MSBs
//   scalar    signed multiplier
//   busy      high while rows are being processed (ROWS cycles)
//   done      single-cycle completion pulse
//   mat_out   result matrix, same packing as mat_in
//   ovf       OR of ovf_rows
//   ovf_rows  bit r set when any element of row r overflowed
// ---------------------------------------------------------------------------
module mat_scalar_mul_seq #(
    parameter int ELEM_W = 8,
    parameter int ROWS   = 5,
    parameter int COLS   = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ROWS*COLS*ELEM_W-1:0] mat_in,
    input  logic [ELEM_W-1:0]           scalar,
    output logic                        busy,
    output logic                        done,
    output logic [ROWS*COLS*ELEM_W-1:0] mat_out,
    output logic                        ovf,
    output logic [ROWS-1:0]             ovf_rows
);

    localparam int MAT_W  = ROWS * COLS * ELEM_W;
    localparam int ROW_W  = COLS * ELEM_W;
    localparam int PROD_W = 2 * ELEM_W;
    localparam int CNT_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state;
    logic [MAT_W-1:0]    mat_reg;
    logic [ELEM_W-1:0]   scalar_reg;
    logic [CNT_W-1:0]    row_cnt;

    logic [ROW_W-1:0]    cur_row;
    logic [ROW_W-1:0]    row_res;
    logic                row_ovf;
    logic [ELEM_W-1:0]   elem;
    logic [PROD_W-1:0]   elem_ext;
    logic [PROD_W-1:0]   scalar_ext;
    logic [PROD_W-1:0]   prod;
    logic [ELEM_W:0]     prod_top;
    logic                lane_ovf;
    logic [ELEM_W-1:0]   lane_res;

    // Pick the latched row addressed by the row counter. A compare per row
    // keeps every part-select constant.
    always_comb begin
        cur_row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_cnt == CNT_W'(r)) begin
                cur_row = mat_reg[(ROWS-1-r)*ROW_W +: ROW_W];
            end
        end
    end

    // COLS multiply lanes. Operands are sign-extended to the full product
    // width, so the low PROD_W bits of the plain product equal the signed
    // product. The product fits in ELEM_W signed bits exactly when its top
    // ELEM_W+1 bits are all equal.
    always_comb begin
        row_res    = '0;
        row_ovf    = 1'b0;
        elem       = '0;
        elem_ext   = '0;
        scalar_ext = {{ELEM_W{scalar_reg[ELEM_W-1]}}, scalar_reg};
        prod       = '0;
        prod_top   = '0;
        lane_ovf   = 1'b0;
        lane_res   = '0;
        for (int c = 0; c < COLS; c++) begin
            elem     = cur_row[(COLS-1-c)*ELEM_W +: ELEM_W];
            elem_ext = {{ELEM_W{elem[ELEM_W-1]}}, elem};
            prod     = elem_ext * scalar_ext;
            prod_top = prod[PROD_W-1:ELEM_W-1];
            lane_ovf = !(&prod_top) && (|prod_top);
`ifdef SAT_EN
            if (lane_ovf) begin
                lane_res = {prod[PROD_W-1], {(ELEM_W-1){~prod[PROD_W-1]}}};
            end else begin
                lane_res = prod[ELEM_W-1:0];
            end
`else
            lane_res = prod[ELEM_W-1:0];
`endif
            row_res[(COLS-1-c)*ELEM_W +: ELEM_W] = lane_res;
            row_ovf = row_ovf | lane_ovf;
        end
    end

    // Control FSM with registered busy/done. busy rises on the accepting
    // edge and falls on the edge that writes the last row, which is also
    // the edge that raises done. A start seen in DONE restarts immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            mat_out    <= '0;
            ovf_rows   <= '0;
            row_cnt    <= '0;
            mat_reg    <= '0;
            scalar_reg <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mat_reg    <= mat_in;
                        scalar_reg <= scalar;
                        mat_out    <= '0;
                        ovf_rows   <= '0;
                        row_cnt    <= '0;
                        busy       <= 1'b1;
                        state      <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    for (int r = 0; r < ROWS; r++) begin
                        if (row_cnt == CNT_W'(r)) begin
                            mat_out[(ROWS-1-r)*ROW_W +: ROW_W] <= row_res;
                            ovf_rows[r] <= row_ovf;
                        end
                    end
                    if (row_cnt == LAST_ROW) begin
                        row_cnt <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        row_cnt <= row_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ovf = |ovf_rows;

endmodule

// File: tb/tb_mat_scalar_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_mat_scalar_mul_seq
//
// Scoreboard bench for mat_scalar_mul_seq with default parameters. The
// stimulus thread computes each expected result matrix with plain integer
// arithmetic and queues it with the cycle its start is accepted. A monitor
// samples the outputs every falling edge and derives from the queue head
// what busy, done, the partially filled mat_out and the overflow flags must
// look like in that cycle. Honours SAT_EN like the design.
// ---------------------------------------------------------------------------
module tb_mat_scalar_mul_seq;

    localparam int W     = 8;
    localparam int ROWS  = 5;
    localparam int COLS  = 5;
    localparam int TOT   = ROWS * COLS * W;
    localparam int ROW_W = COLS * W;
    localparam int MAXV  = (1 << (W - 1)) - 1;
    localparam int MINV  = -(1 << (W - 1));

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [TOT-1:0]  mat_in;
    logic [W-1:0]    scalar;
    logic            busy;
    logic            done;
    logic [TOT-1:0]  mat_out;
    logic            ovf;
    logic [ROWS-1:0] ovf_rows;

    typedef struct {
        logic [TOT-1:0]  mat;
        logic [ROWS-1:0] orows;
        int              acc;
    } exp_t;

    exp_t            sb[$];
    logic [TOT-1:0]  hold_mat  = '0;
    logic [ROWS-1:0] hold_rows = '0;
    int              cyc        = 0;
    int              compared   = 0;
    int              mismatched = 0;
    bit              mon_en     = 1'b0;

    logic            mon_busy;
    logic            mon_done;
    logic [TOT-1:0]  mon_mat;
    logic [ROWS-1:0] mon_rows;
    int              mon_k;

    mat_scalar_mul_seq #(
        .ELEM_W(W),
        .ROWS  (ROWS),
        .COLS  (COLS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mat_in  (mat_in),
        .scalar  (scalar),
        .busy    (busy),
        .done    (done),
        .mat_out (mat_out),
        .ovf     (ovf),
        .ovf_rows(ovf_rows)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic int elemIdx(input int r, input int c);
        return ((ROWS * COLS - 1) - (r * COLS + c)) * W;
    endfunction

    function automatic logic [TOT-1:0] fillMat(input int v);
        logic [TOT-1:0] m;
        for (int i = 0; i < ROWS * COLS; i++) m[i*W +: W] = W'(v);
        return m;
    endfunction

    function automatic logic [TOT-1:0] putElem(input logic [TOT-1:0] m, input int r,
                                               input int c, input int v);
        logic [TOT-1:0] t;
        t = m;
        t[elemIdx(r, c) +: W] = W'(v);
        return t;
    endfunction

    // Reference: signed integer product per element, range test against the
    // ELEM_W signed range, then either saturate or keep the low W bits.
    function automatic void modelResult(input logic [TOT-1:0] m, input logic [W-1:0] s,
                                        output logic [TOT-1:0] res,
                                        output logic [ROWS-1:0] orows);
        int e;
        int sv;
        int p;
        int q;
        res   = '0;
        orows = '0;
        sv    = $signed(s);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                e = $signed(m[elemIdx(r, c) +: W]);
                p = e * sv;
                q = p;
                if (p > MAXV || p < MINV) begin
                    orows[r] = 1'b1;
`ifdef SAT_EN
                    q = (p > 0) ? MAXV : MINV;
`endif
                end
                res[elemIdx(r, c) +: W] = W'(q);
            end
        end
    endfunction

    function automatic logic [TOT-1:0] rowsUpTo(input logic [TOT-1:0] m, input int k);
        logic [TOT-1:0] t;
        t = '0;
        for (int r = 0; r < ROWS; r++)
            if (r < k) t[(ROWS-1-r)*ROW_W +: ROW_W] = m[(ROWS-1-r)*ROW_W +: ROW_W];
        return t;
    endfunction

    function automatic logic [ROWS-1:0] rowMask(input int k);
        logic [ROWS-1:0] t;
        t = '0;
        for (int r = 0; r < ROWS; r++) if (r < k) t[r] = 1'b1;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [TOT-1:0] act,
                               input logic [TOT-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: k is the number of rising edges since the head operation's
    // start was accepted. Rows 0..k-1 are visible while busy; done shows at k=ROWS.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_busy = 1'b0;
            mon_done = 1'b0;
            mon_mat  = hold_mat;
            mon_rows = hold_rows;
            mon_k    = -1;
            if (sb.size() > 0) begin
                mon_k = cyc - sb[0].acc;
                if (mon_k >= 0 && mon_k < ROWS) begin
                    mon_busy = 1'b1;
                    mon_mat  = rowsUpTo(sb[0].mat, mon_k);
                    mon_rows = sb[0].orows & rowMask(mon_k);
                end else if (mon_k == ROWS) begin
                    mon_done = 1'b1;
                    mon_mat  = sb[0].mat;
                    mon_rows = sb[0].orows;
                end
            end
            checkOutput("busy", TOT'(busy), TOT'(mon_busy));
            checkOutput("done", TOT'(done), TOT'(mon_done));
            checkOutput("mat_out", mat_out, mon_mat);
            checkOutput("ovf_rows", TOT'(ovf_rows), TOT'(mon_rows));
            checkOutput("ovf", TOT'(ovf), TOT'(|mon_rows));
            if (mon_k == ROWS) begin
                hold_mat  = mon_mat;
                hold_rows = mon_rows;
                sb.delete(0);
            end
        end
    end

    task automatic nextCycle();
        @(negedge clk);
        #1;
    endtask

    // Drives one start for a cycle and queues its expected result.
    task automatic applyStimulus(input logic [TOT-1:0] m, input logic [W-1:0] s);
        exp_t e;
        mat_in = m;
        scalar = s;
        start  = 1'b1;
        modelResult(m, s, e.mat, e.orows);
        e.acc = cyc + 1;
        sb.push_back(e);
        nextCycle();
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) return;
            nextCycle();
        end
        compared++;
        mismatched++;
        $display("[TB] FAIL wait_done: no done within %0d cycles at cycle %0d", budget, cyc);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [TOT-1:0] m;

        rst    = 1'b1;
        start  = 1'b0;
        mat_in = '0;
        scalar = '0;
        repeat (2) nextCycle();
        checkOutput("reset_busy", TOT'(busy), '0);
        checkOutput("reset_done", TOT'(done), '0);
        checkOutput("reset_mat_out", mat_out, '0);
        checkOutput("reset_ovf_rows", TOT'(ovf_rows), '0);
        checkOutput("reset_ovf", TOT'(ovf), '0);
        rst    = 1'b0;
        mon_en = 1'b1;
        nextCycle();

        $display("[TB] all elements 3, scalar 4");
        applyStimulus(fillMat(3), W'(4));
        waitDone(ROWS + 5);
        nextCycle();

        $display("[TB] single overflow in row 2");
        m = putElem(fillMat(1), 2, 0, 100);
        applyStimulus(m, W'(2));
        waitDone(ROWS + 5);
        nextCycle();

        $display("[TB] -128 * -1 and scalar 0");
        m = putElem(fillMat(1), 4, 4, -128);
        applyStimulus(m, W'(-1));
        waitDone(ROWS + 5);
        nextCycle();
        applyStimulus(m, W'(0));
        waitDone(ROWS + 5);
        nextCycle();

        $display("[TB] start re-pulsed during RUN");
        applyStimulus(fillMat(-5), W'(3));
        nextCycle();
        mat_in = fillMat(7);
        scalar = W'(9);
        start  = 1'b1;
        nextCycle();
        start  = 1'b0;
        waitDone(ROWS + 5);
        nextCycle();

        $display("[TB] reset while row 3 is processing");
        applyStimulus(fillMat(2), W'(-3));
        repeat (3) nextCycle();
        rst       = 1'b1;
        sb.delete();
        hold_mat  = '0;
        hold_rows = '0;
        nextCycle();
        rst = 1'b0;
        checkOutput("midrst_busy", TOT'(busy), '0);
        checkOutput("midrst_done", TOT'(done), '0);
        checkOutput("midrst_mat_out", mat_out, '0);
        checkOutput("midrst_ovf", TOT'(ovf), '0);
        applyStimulus(fillMat(-7), W'(20));
        waitDone(ROWS + 5);
        nextCycle();

        $display("[TB] back-to-back via start in DONE");
        applyStimulus(fillMat(11), W'(-2));
        waitDone(ROWS + 5);
        applyStimulus(fillMat(60), W'(5));
        waitDone(ROWS + 5);
        nextCycle();

        $display("[TB] randomized operations");
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < ROWS * COLS; i++)
                m[i*W +: W] = (n % 3 == 0) ? W'($urandom_range(0, 7)) : W'($urandom);
            applyStimulus(m, W'($urandom));
            waitDone(ROWS + 5);
            if ($urandom_range(0, 1) == 0) nextCycle();
        end

        repeat (3) nextCycle();
        checkOutput("scoreboard_drained", TOT'(sb.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
